// File: rtl/regbank_ctrl.sv
// Sequencer/arbiter in front of the 37-entry ARM register bank: arbitrates reads, two write-back
// streams and CPSR updates, and maps r0-r15 to banked indices. REGBANK_CTRL_RR_EN selects wa/wb round-robin.
module regbank_ctrl #(
   parameter int         DW         = 32,
   parameter logic [4:0] RESET_MODE = 5'b10011
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd_valid,
   output logic          rd_ready,
   input  logic [3:0]    rd_addr1,
   input  logic [3:0]    rd_addr2,
   input  logic [3:0]    rd_addr3,
   output logic [DW-1:0] rd_data1,
   output logic [DW-1:0] rd_data2,
   output logic [DW-1:0] rd_data3,
   output logic          rd_done,
   input  logic          wa_valid,
   output logic          wa_ready,
   input  logic [3:0]    wa_addr,
   input  logic [DW-1:0] wa_data,
   input  logic          wb_valid,
   output logic          wb_ready,
   input  logic [3:0]    wb_addr,
   input  logic [DW-1:0] wb_data,
   input  logic          cpsr_valid,
   output logic          cpsr_ready,
   input  logic [DW-1:0] cpsr_data,
   input  logic [DW-1:0] cpsr_mask,
   input  logic          pc_inc_req,
   output logic [4:0]    mode,
   output logic          bk_active,
   output logic          bk_w,
   output logic          bk_pc_w,
   output logic          bk_cpsr_w,
   output logic          bk_pc_inc,
   output logic [5:0]    bk_addr1,
   output logic [5:0]    bk_addr2,
   output logic [5:0]    bk_addr3,
   output logic [DW-1:0] bk_write,
   output logic [DW-1:0] bk_pc_write,
   output logic [DW-1:0] bk_cpsr_write,
   output logic [DW-1:0] bk_cpsr_mask,
   input  logic [DW-1:0] bk_read1,
   input  logic [DW-1:0] bk_read2,
   input  logic [DW-1:0] bk_read3
);

   typedef enum logic [2:0] {IDLE, RD, RD_CAP, WR, PCW, CPSRW} state_t;

   state_t r_state;

   logic          w_idle;
   logic          w_pickWb;
   logic          w_grantWb;
   logic          w_grantWa;
   logic          w_grantWr;
   logic          w_grantRd;
   logic [3:0]    w_wrAddr;
   logic [DW-1:0] w_wrData;
   logic          w_wrIsPc;

   // Banked physical index for a logical register under a given mode; unknown modes map identically.
   function automatic logic [5:0] mapReg(input logic [3:0] r, input logic [4:0] m);
      logic [5:0] idx;
      logic [5:0] res;
      idx = {2'b00, r};
      res = idx;
      case (m)
         5'b10001: if (r >= 4'd8 && r <= 4'd14) res = idx + 6'd8;
         5'b10011: if (r == 4'd13 || r == 4'd14) res = idx + 6'd10;
         5'b10111: if (r == 4'd13 || r == 4'd14) res = idx + 6'd12;
         5'b10010: if (r == 4'd13 || r == 4'd14) res = idx + 6'd14;
         5'b11011: if (r == 4'd13 || r == 4'd14) res = idx + 6'd16;
         default:  res = idx;
      endcase
      return res;
   endfunction

`ifdef REGBANK_CTRL_RR_EN
   logic r_lastWb;
   assign w_pickWb = wb_valid && (!wa_valid || !r_lastWb);
`else
   assign w_pickWb = wb_valid;
`endif

   assign w_idle     = (r_state == IDLE) && !rst;
   assign w_grantWb  = w_idle && !cpsr_valid && w_pickWb;
   assign w_grantWa  = w_idle && !cpsr_valid && wa_valid && !w_pickWb;
   assign w_grantWr  = w_grantWa || w_grantWb;
   assign w_grantRd  = w_idle && !cpsr_valid && !wa_valid && !wb_valid && rd_valid;
   assign w_wrAddr   = w_pickWb ? wb_addr : wa_addr;
   assign w_wrData   = w_pickWb ? wb_data : wa_data;
   assign w_wrIsPc   = (w_wrAddr == 4'd15);

   assign cpsr_ready = w_idle && cpsr_valid;
   assign wb_ready   = w_grantWb;
   assign wa_ready   = w_grantWa;
   assign rd_ready   = w_grantRd;

   // Strobes are one-cycle registered pulses; address and data registers hold between transactions.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         mode          <= RESET_MODE;
         bk_active     <= 1'b0;
         bk_w          <= 1'b0;
         bk_pc_w       <= 1'b0;
         bk_cpsr_w     <= 1'b0;
         bk_pc_inc     <= 1'b0;
         bk_addr1      <= '0;
         bk_addr2      <= '0;
         bk_addr3      <= '0;
         bk_write      <= '0;
         bk_pc_write   <= '0;
         bk_cpsr_write <= '0;
         bk_cpsr_mask  <= '0;
         rd_data1      <= '0;
         rd_data2      <= '0;
         rd_data3      <= '0;
         rd_done       <= 1'b0;
`ifdef REGBANK_CTRL_RR_EN
         r_lastWb      <= 1'b0;
`endif
      end else begin
         bk_active <= 1'b0;
         bk_w      <= 1'b0;
         bk_pc_w   <= 1'b0;
         bk_cpsr_w <= 1'b0;
         rd_done   <= 1'b0;
         bk_pc_inc <= pc_inc_req && !(w_grantWr && w_wrIsPc);
         case (r_state)
            IDLE: begin
               if (cpsr_ready) begin
                  bk_cpsr_write <= cpsr_data;
                  bk_cpsr_mask  <= cpsr_mask;
                  bk_cpsr_w     <= 1'b1;
                  r_state       <= CPSRW;
               end else if (w_grantWr) begin
`ifdef REGBANK_CTRL_RR_EN
                  r_lastWb <= w_grantWb;
`endif
                  if (w_wrIsPc) begin
                     bk_pc_write <= w_wrData;
                     bk_pc_w     <= 1'b1;
                     r_state     <= PCW;
                  end else begin
                     bk_addr1 <= mapReg(w_wrAddr, mode);
                     bk_write <= w_wrData;
                     bk_w     <= 1'b1;
                     r_state  <= WR;
                  end
               end else if (w_grantRd) begin
                  bk_addr1  <= mapReg(rd_addr1, mode);
                  bk_addr2  <= mapReg(rd_addr2, mode);
                  bk_addr3  <= mapReg(rd_addr3, mode);
                  bk_active <= 1'b1;
                  r_state   <= RD;
               end
            end
            RD: begin
               rd_data1 <= bk_read1;
               rd_data2 <= bk_read2;
               rd_data3 <= bk_read3;
               rd_done  <= 1'b1;
               r_state  <= RD_CAP;
            end
            CPSRW: begin
               mode    <= (mode & ~bk_cpsr_mask[4:0]) | (bk_cpsr_write[4:0] & bk_cpsr_mask[4:0]);
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regbank_ctrl.sv
// Directed bench for regbank_ctrl with a small behavioural 37-entry bank attached to the bk_* port.
module tb_regbank_ctrl;

   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic          rd_valid, rd_ready, rd_done;
   logic [3:0]    rd_addr1, rd_addr2, rd_addr3;
   logic [DW-1:0] rd_data1, rd_data2, rd_data3;
   logic          wa_valid, wa_ready, wb_valid, wb_ready;
   logic [3:0]    wa_addr, wb_addr;
   logic [DW-1:0] wa_data, wb_data;
   logic          cpsr_valid, cpsr_ready;
   logic [DW-1:0] cpsr_data, cpsr_mask;
   logic          pc_inc_req;
   logic [4:0]    mode;
   logic          bk_active, bk_w, bk_pc_w, bk_cpsr_w, bk_pc_inc;
   logic [5:0]    bk_addr1, bk_addr2, bk_addr3;
   logic [DW-1:0] bk_write, bk_pc_write, bk_cpsr_write, bk_cpsr_mask;
   logic [DW-1:0] bk_read1, bk_read2, bk_read3;

   logic [DW-1:0] bankMem [0:36];
   int totalChecks = 0;
   int badChecks   = 0;
   logic expWb;

   regbank_ctrl #(.DW(DW), .RESET_MODE(5'b10011)) dut (
      .clk(clk), .rst(rst),
      .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
      .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3), .rd_done(rd_done),
      .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .cpsr_valid(cpsr_valid), .cpsr_ready(cpsr_ready), .cpsr_data(cpsr_data), .cpsr_mask(cpsr_mask),
      .pc_inc_req(pc_inc_req), .mode(mode),
      .bk_active(bk_active), .bk_w(bk_w), .bk_pc_w(bk_pc_w), .bk_cpsr_w(bk_cpsr_w), .bk_pc_inc(bk_pc_inc),
      .bk_addr1(bk_addr1), .bk_addr2(bk_addr2), .bk_addr3(bk_addr3),
      .bk_write(bk_write), .bk_pc_write(bk_pc_write), .bk_cpsr_write(bk_cpsr_write), .bk_cpsr_mask(bk_cpsr_mask),
      .bk_read1(bk_read1), .bk_read2(bk_read2), .bk_read3(bk_read3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank fixture: entry i resets to 0x1000+i, writes land on the edge ending the strobe cycle.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 37; i++) bankMem[i] <= 32'h1000 + i;
      end else begin
         if (bk_w && bk_addr1 <= 6'd36) bankMem[bk_addr1] <= bk_write;
         if (bk_pc_w) bankMem[15] <= bk_pc_write;
      end
   end

   assign bk_read1 = (bk_addr1 <= 6'd36) ? bankMem[bk_addr1] : '0;
   assign bk_read2 = (bk_addr2 <= 6'd36) ? bankMem[bk_addr2] : '0;
   assign bk_read3 = (bk_addr3 <= 6'd36) ? bankMem[bk_addr3] : '0;

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      totalChecks++;
      assert (obs === exp) else begin
         badChecks++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      rd_valid = 0; rd_addr1 = 0; rd_addr2 = 0; rd_addr3 = 0;
      wa_valid = 0; wa_addr = 0; wa_data = 0;
      wb_valid = 0; wb_addr = 0; wb_data = 0;
      cpsr_valid = 0; cpsr_data = 0; cpsr_mask = 0;
      pc_inc_req = 0;

      // Reset state, with a requester already waiting
      wa_valid = 1'b1;
      applyStimulus(2);
      checkOutput("rst_wa_ready", wa_ready, 0);
      checkOutput("rst_mode", mode, 5'b10011);
      checkOutput("rst_bk_w", bk_w, 0);
      checkOutput("rst_bk_active", bk_active, 0);
      checkOutput("rst_bk_addr1", bk_addr1, 0);
      checkOutput("rst_bk_write", bk_write, 0);
      checkOutput("rst_rd_done", rd_done, 0);
      checkOutput("rst_rd_data1", rd_data1, 0);
      wa_valid = 1'b0;
      rst = 1'b0;
      applyStimulus(1);

      // wa writes r13 in SVC, then read it back
      wa_valid = 1; wa_addr = 4'd13; wa_data = 32'hDEADBEEF;
      #1 checkOutput("a_wa_ready", wa_ready, 1);
      applyStimulus(1);
      wa_valid = 0;
      checkOutput("a_bk_w", bk_w, 1);
      checkOutput("a_bk_addr1", bk_addr1, 23);
      checkOutput("a_bk_write", bk_write, 32'hDEADBEEF);
      applyStimulus(1);
      checkOutput("a_bk_w_clr", bk_w, 0);
      rd_valid = 1; rd_addr1 = 4'd13; rd_addr2 = 4'd0; rd_addr3 = 4'd14;
      #1 checkOutput("a_rd_ready", rd_ready, 1);
      applyStimulus(1);
      rd_valid = 0;
      checkOutput("a_bk_active", bk_active, 1);
      checkOutput("a_rd_addr1", bk_addr1, 23);
      checkOutput("a_rd_addr3", bk_addr3, 24);
      checkOutput("a_rd_done_early", rd_done, 0);
      applyStimulus(1);
      checkOutput("a_rd_done", rd_done, 1);
      checkOutput("a_rd_data1", rd_data1, 32'hDEADBEEF);
      checkOutput("a_rd_data2", rd_data2, 32'h1000);
      checkOutput("a_rd_data3", rd_data3, 32'h1018);
      applyStimulus(1);
      checkOutput("a_rd_done_clr", rd_done, 0);

      // CPSR to FIQ, then read r8, r9, r14
      cpsr_valid = 1; cpsr_data = 32'h11; cpsr_mask = 32'h1F;
      #1 checkOutput("b_cpsr_ready", cpsr_ready, 1);
      applyStimulus(1);
      cpsr_valid = 0;
      checkOutput("b_bk_cpsr_w", bk_cpsr_w, 1);
      checkOutput("b_bk_cpsr_write", bk_cpsr_write, 32'h11);
      checkOutput("b_bk_cpsr_mask", bk_cpsr_mask, 32'h1F);
      checkOutput("b_mode_before", mode, 5'b10011);
      applyStimulus(1);
      checkOutput("b_mode_fiq", mode, 5'b10001);
      rd_valid = 1; rd_addr1 = 4'd8; rd_addr2 = 4'd9; rd_addr3 = 4'd14;
      applyStimulus(1);
      rd_valid = 0;
      checkOutput("b_bk_addr1", bk_addr1, 16);
      checkOutput("b_bk_addr2", bk_addr2, 17);
      checkOutput("b_bk_addr3", bk_addr3, 22);
      applyStimulus(1);
      checkOutput("b_rd_data1", rd_data1, 32'h1010);
      applyStimulus(1);

      // wa (r1) and wb (r2) contend for three rounds
      wa_valid = 1; wa_addr = 4'd1; wa_data = 32'hA1;
      wb_valid = 1; wb_addr = 4'd2; wb_data = 32'hB2;
      for (int k = 0; k < 3; k++) begin
`ifdef REGBANK_CTRL_RR_EN
         expWb = (k != 1);
`else
         expWb = 1'b1;
`endif
         #1;
         checkOutput($sformatf("c_wb_ready%0d", k), wb_ready, expWb);
         checkOutput($sformatf("c_wa_ready%0d", k), wa_ready, !expWb);
         applyStimulus(1);
         checkOutput($sformatf("c_bk_addr1_%0d", k), bk_addr1, expWb ? 32'd2 : 32'd1);
         checkOutput($sformatf("c_bk_write%0d", k), bk_write, expWb ? 32'hB2 : 32'hA1);
         checkOutput($sformatf("c_busy_ready%0d", k), wa_ready | wb_ready, 0);
         applyStimulus(1);
      end
      wa_valid = 0; wb_valid = 0;

      // PC increment alone, then colliding with a write to r15
      pc_inc_req = 1;
      applyStimulus(1);
      pc_inc_req = 0;
      checkOutput("d_pc_inc", bk_pc_inc, 1);
      applyStimulus(1);
      checkOutput("d_pc_inc_clr", bk_pc_inc, 0);
      wa_valid = 1; wa_addr = 4'd15; wa_data = 32'h100; pc_inc_req = 1;
      #1 checkOutput("d_wa_ready", wa_ready, 1);
      applyStimulus(1);
      wa_valid = 0; pc_inc_req = 0;
      checkOutput("d_bk_pc_w", bk_pc_w, 1);
      checkOutput("d_bk_pc_write", bk_pc_write, 32'h100);
      checkOutput("d_pc_inc_drop", bk_pc_inc, 0);
      checkOutput("d_bk_w", bk_w, 0);
      applyStimulus(1);
      checkOutput("d_bk_pc_w_clr", bk_pc_w, 0);

      // cpsr, wa and rd offered together
      cpsr_valid = 1; cpsr_data = 32'h13; cpsr_mask = 32'h1F;
      wa_valid = 1; wa_addr = 4'd13; wa_data = 32'h55;
      rd_valid = 1; rd_addr1 = 4'd13; rd_addr2 = 4'd14; rd_addr3 = 4'd0;
      #1;
      checkOutput("e_cpsr_ready", cpsr_ready, 1);
      checkOutput("e_wa_ready0", wa_ready, 0);
      checkOutput("e_rd_ready0", rd_ready, 0);
      applyStimulus(1);
      cpsr_valid = 0;
      checkOutput("e_bk_cpsr_w", bk_cpsr_w, 1);
      applyStimulus(1);
      #1;
      checkOutput("e_mode_svc", mode, 5'b10011);
      checkOutput("e_wa_ready2", wa_ready, 1);
      checkOutput("e_rd_ready2", rd_ready, 0);
      applyStimulus(1);
      wa_valid = 0;
      checkOutput("e_bk_w", bk_w, 1);
      checkOutput("e_bk_addr1_w", bk_addr1, 23);
      applyStimulus(1);
      #1 checkOutput("e_rd_ready4", rd_ready, 1);
      applyStimulus(1);
      rd_valid = 0;
      checkOutput("e_bk_active", bk_active, 1);
      checkOutput("e_rd_done5", rd_done, 0);
      applyStimulus(1);
      checkOutput("e_rd_done6", rd_done, 1);
      checkOutput("e_rd_data1", rd_data1, 32'h55);
      checkOutput("e_rd_data2", rd_data2, 32'h1018);
      checkOutput("e_rd_data3", rd_data3, 32'h1000);
      applyStimulus(1);

      // Move to SYS, then reset in the middle of a read
      cpsr_valid = 1; cpsr_data = 32'h1F; cpsr_mask = 32'h1F;
      applyStimulus(1);
      cpsr_valid = 0;
      applyStimulus(1);
      checkOutput("f_mode_sys", mode, 5'b11111);
      rd_valid = 1; rd_addr1 = 4'd0; rd_addr2 = 4'd1; rd_addr3 = 4'd2;
      applyStimulus(1);
      rd_valid = 0;
      checkOutput("f_bk_active", bk_active, 1);
      rst = 1;
      applyStimulus(1);
      checkOutput("f_bk_active_clr", bk_active, 0);
      checkOutput("f_rd_done_rst", rd_done, 0);
      checkOutput("f_mode_rst", mode, 5'b10011);
      rst = 0;
      applyStimulus(1);
      checkOutput("f_rd_done_after", rd_done, 0);
      rd_valid = 1;
      #1 checkOutput("f_idle_rd_ready", rd_ready, 1);
      rd_valid = 0;
      applyStimulus(2);
      checkOutput("f_no_rd_done", rd_done, 0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
